// File: rtl/bit_cptn.sv
// Generic-width up/down counter: programmable modulus, parallel load, wrap or saturate, tc strobe, sticky ovf.
// Optional synchronous clear input when BIT_CPTN_CLEAR_EN is defined.
module bit_cptn #(
  parameter int WIDTH = 3,
  parameter int MAX   = 7,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef BIT_CPTN_CLEAR_EN
  input  logic             clear,
`endif
  output logic [WIDTH-1:0] cpt,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("bit_cptn: WIDTH must be in 1..32");
    end
    if (MAX < 1 || 64'(MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("bit_cptn: MAX must satisfy 0 < MAX <= 2**WIDTH-1");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Value taken when a step would leave 0..MAX: pin in saturate mode, wrap otherwise.
  function automatic logic [WIDTH-1:0] range_end(input logic [WIDTH-1:0] cur, input logic dir_up);
    if (SAT != 0) return cur;
    return dir_up ? '0 : MAX_V;
  endfunction

  logic [WIDTH-1:0] r_cpt;
  logic             r_ovf;
  logic             w_clear;
  logic             w_at_end;
  logic [WIDTH-1:0] w_step;

`ifdef BIT_CPTN_CLEAR_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif

  assign w_at_end = up ? (r_cpt == MAX_V) : (r_cpt == '0);
  assign w_step   = up ? (r_cpt + WIDTH'(1)) : (r_cpt - WIDTH'(1));

  assign tc  = reset & activate & ~load & ~w_clear & w_at_end;
  assign cpt = r_cpt;
  assign ovf = r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpt <= '0;
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_cpt <= '0;
      r_ovf <= 1'b0;
    end else if (load) begin
      r_cpt <= clamp_max(load_val);
      r_ovf <= 1'b0;
    end else if (activate) begin
      if (w_at_end) begin
        r_cpt <= range_end(r_cpt, up);
        r_ovf <= 1'b1;
      end else begin
        r_cpt <= w_step;
      end
    end
  end

endmodule

// File: tb/tb_bit_cptn.sv
// Randomized bench for bit_cptn: three instances (wrap MAX=7, wrap MAX=4, saturate MAX=4) vs. an arithmetic model.
module tb_bit_cptn;

  logic       clk;
  logic       reset;
  logic       activate;
  logic       up;
  logic       load;
  logic [2:0] load_val;
  logic       clear;
  logic [2:0] cpt_o [3];
  logic       tc_o  [3];
  logic       ovf_o [3];

  int maxs [3] = '{7, 4, 4};
  int sats [3] = '{0, 0, 1};
  int m_cpt [3];
  bit m_ovf [3];
  int checks = 0;
  int errors = 0;

  bit_cptn #(.WIDTH(3), .MAX(7), .SAT(0)) u_w7 (
    .clk(clk), .reset(reset), .activate(activate), .up(up), .load(load), .load_val(load_val),
`ifdef BIT_CPTN_CLEAR_EN
    .clear(clear),
`endif
    .cpt(cpt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

  bit_cptn #(.WIDTH(3), .MAX(4), .SAT(0)) u_w4 (
    .clk(clk), .reset(reset), .activate(activate), .up(up), .load(load), .load_val(load_val),
`ifdef BIT_CPTN_CLEAR_EN
    .clear(clear),
`endif
    .cpt(cpt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

  bit_cptn #(.WIDTH(3), .MAX(4), .SAT(1)) u_s4 (
    .clk(clk), .reset(reset), .activate(activate), .up(up), .load(load), .load_val(load_val),
`ifdef BIT_CPTN_CLEAR_EN
    .clear(clear),
`endif
    .cpt(cpt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_tc(int i);
    if (!reset || !activate || load || clear) return 1'b0;
    return up ? (m_cpt[i] == maxs[i]) : (m_cpt[i] == 0);
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 3; i++) begin
      m_cpt[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // Advance one rising edge, update the model from the inputs seen there, then settle.
  task automatic cycle();
    int n;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!reset || clear) begin
        m_cpt[i] = 0;
        m_ovf[i] = 1'b0;
      end else if (load) begin
        m_cpt[i] = (int'(load_val) > maxs[i]) ? maxs[i] : int'(load_val);
        m_ovf[i] = 1'b0;
      end else if (activate) begin
        n = m_cpt[i] + (up ? 1 : -1);
        if (n < 0 || n > maxs[i]) begin
          m_ovf[i] = 1'b1;
          if (sats[i] != 0) n = m_cpt[i];
          else n = (n < 0) ? maxs[i] : 0;
        end
        m_cpt[i] = n;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_zero();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    activate = 1'b1; up = 1'b1; load = 1'b0; load_val = 3'd0; clear = 1'b0;
    reset = 1'b0;
    model_zero();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cpt_o[i] !== 3'd0 || ovf_o[i] !== 1'b0 || tc_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] got cpt=%0d ovf=%b tc=%b exp 0/0/0", i, cpt_o[i], ovf_o[i], tc_o[i]);
      end
    end
    cycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cpt_o[i] !== 3'd0 || ovf_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d] got cpt=%0d ovf=%b exp 0/0", i, cpt_o[i], ovf_o[i]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic run_steps(string name, int steps);
    for (int k = 0; k < steps; k++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tc_o[i] !== exp_tc(i)) begin
          errors++;
          $display("FAIL %s_tc[%0d] step %0d got %b exp %b", name, i, k, tc_o[i], exp_tc(i));
        end
      end
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cpt_o[i] !== 3'(m_cpt[i]) || ovf_o[i] !== m_ovf[i]) begin
          errors++;
          $display("FAIL %s[%0d] step %0d got cpt=%0d ovf=%b exp cpt=%0d ovf=%b",
                   name, i, k, cpt_o[i], ovf_o[i], m_cpt[i], m_ovf[i]);
        end
      end
    end
  endtask

  task automatic test_count_up();
    int seq [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    do_reset();
    activate = 1'b1; up = 1'b1; load = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #1;
      checks++;
      if (tc_o[0] !== (cpt_o[0] == 3'd7)) begin
        errors++;
        $display("FAIL up_tc step %0d got %b with cpt=%0d", k, tc_o[0], cpt_o[0]);
      end
      cycle();
      checks++;
      if (cpt_o[0] !== 3'(seq[k]) || ovf_o[0] !== (k >= 7)) begin
        errors++;
        $display("FAIL up_seq step %0d got cpt=%0d ovf=%b exp cpt=%0d ovf=%b",
                 k, cpt_o[0], ovf_o[0], seq[k], (k >= 7));
      end
    end
    do_reset();
    run_steps("up", 9);
  endtask

  task automatic test_count_down();
    int seq [6] = '{4, 3, 2, 1, 0, 4};
    do_reset();
    activate = 1'b1; up = 1'b0; load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if (cpt_o[1] !== 3'(seq[k]) || ovf_o[1] !== 1'b1) begin
        errors++;
        $display("FAIL down_seq step %0d got cpt=%0d ovf=%b exp cpt=%0d ovf=1", k, cpt_o[1], ovf_o[1], seq[k]);
      end
    end
    do_reset();
    run_steps("down", 6);
  endtask

  task automatic test_saturate();
    int seq [7] = '{1, 2, 3, 4, 4, 4, 4};
    do_reset();
    activate = 1'b1; up = 1'b1; load = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      checks++;
      if (cpt_o[2] !== 3'(seq[k]) || ovf_o[2] !== (k >= 4) || tc_o[2] !== (k >= 3)) begin
        errors++;
        $display("FAIL sat_seq step %0d got cpt=%0d ovf=%b tc=%b exp cpt=%0d ovf=%b tc=%b",
                 k, cpt_o[2], ovf_o[2], tc_o[2], seq[k], (k >= 4), (k >= 3));
      end
    end
    do_reset();
    run_steps("sat", 7);
  endtask

  task automatic test_load();
    do_reset();
    activate = 1'b1; up = 1'b1; load = 1'b0;
    run_steps("pre_load", 13);
    load = 1'b1; load_val = 3'd2;
    run_steps("load", 1);
    checks++;
    if (cpt_o[0] !== 3'd2 || ovf_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL load_w7 got cpt=%0d ovf=%b exp cpt=2 ovf=0", cpt_o[0], ovf_o[0]);
    end
    load_val = 3'd6;
    run_steps("clamp", 1);
    checks++;
    if (cpt_o[1] !== 3'd4 || cpt_o[2] !== 3'd4 || cpt_o[0] !== 3'd6) begin
      errors++;
      $display("FAIL clamp got %0d/%0d/%0d exp 6/4/4", cpt_o[0], cpt_o[1], cpt_o[2]);
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    int seq [3] = '{1, 2, 3};
    do_reset();
    activate = 1'b1; up = 1'b1; load = 1'b0;
    run_steps("pre_areset", 7);
    #2;
    reset = 1'b0;
    model_zero();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cpt_o[i] !== 3'd0 || ovf_o[i] !== 1'b0 || tc_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL areset[%0d] got cpt=%0d ovf=%b tc=%b exp 0/0/0", i, cpt_o[i], ovf_o[i], tc_o[i]);
      end
    end
    cycle();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (cpt_o[0] !== 3'(seq[k])) begin
        errors++;
        $display("FAIL resume step %0d got cpt=%0d exp %0d", k, cpt_o[0], seq[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      activate = ($urandom_range(3) != 0);
      up       = $urandom_range(1);
      load     = ($urandom_range(7) == 0);
      load_val = 3'($urandom_range(7));
`ifdef BIT_CPTN_CLEAR_EN
      clear    = ($urandom_range(15) == 0);
`endif
      reset    = ($urandom_range(49) != 0);
      if (!reset) model_zero();
      run_steps("rand", 1);
    end
    reset = 1'b1; clear = 1'b0; load = 1'b0;
  endtask

`ifdef BIT_CPTN_CLEAR_EN
  task automatic test_clear();
    do_reset();
    activate = 1'b1; up = 1'b1; load = 1'b0;
    run_steps("pre_clear", 6);
    clear = 1'b1; load = 1'b1; load_val = 3'd3;
    #1;
    checks++;
    if (tc_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_tc got %b exp 0", tc_o[0]);
    end
    cycle();
    checks++;
    if (cpt_o[0] !== 3'd0 || ovf_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear got cpt=%0d ovf=%b exp 0/0", cpt_o[0], ovf_o[0]);
    end
    clear = 1'b0; load = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load();
    test_async_reset();
`ifdef BIT_CPTN_CLEAR_EN
    test_clear();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
